// File: rtl/kid_collision_pkg.sv
// kid_collision_pkg
//   Shared types and constants for the Kid collision scanner.
//   tile_t        : tile-map codes (code 3 is not listed and behaves as empty)
//   probe_idx_t   : probe slot number within one scan
//   scan_state_t  : scanner FSM states
//   Optional feature macro: KID_GOD_MODE_EN (drops the four spike probes).
package kid_collision_pkg;

    localparam int TILE_SZ    = 32;
    localparam int TILE_SHIFT = 5;
    localparam int MAP_COLS   = 20;
    localparam int MAP_ROWS   = 15;
    localparam int KID_W      = 32;
    localparam int KID_H      = 32;
    localparam int SCREEN_W   = MAP_COLS * TILE_SZ;
    localparam int SCREEN_H   = MAP_ROWS * TILE_SZ;

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_SOLID = 2'd1,
        TILE_SPIKE = 2'd2
    } tile_t;

    typedef logic [3:0] probe_idx_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROBE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } scan_state_t;

    // Probes 0..5 test for solid tiles, 6..9 for spikes.
    localparam probe_idx_t P_SPIKE0 = 4'd6;

`ifdef KID_GOD_MODE_EN
    localparam probe_idx_t LAST_PROBE = 4'd5;
`else
    localparam probe_idx_t LAST_PROBE = 4'd9;
`endif

    function automatic logic is_solid(input logic [1:0] code);
        return code == TILE_SOLID;
    endfunction

    function automatic logic is_spike(input logic [1:0] code);
        return code == TILE_SPIKE;
    endfunction

endpackage

// File: rtl/kid_tile_addr.sv
// kid_tile_addr
//   Combinational pixel -> tile-map translation.
//   px, py     : pixel coordinate (unsigned, so negative positions wrap high)
//   oob        : coordinate lies outside the 640x480 playfield
//   tile_addr  : row*MAP_COLS+col, forced to 0 when oob
//   row        : tile row, reported as MAP_ROWS (15) when py is below the screen
module kid_tile_addr
    import kid_collision_pkg::*;
(
    input  logic [9:0] px,
    input  logic [9:0] py,
    output logic       oob,
    output logic [8:0] tile_addr,
    output logic [3:0] row
);

    logic       x_oob;
    logic       y_oob;
    logic [4:0] col_raw;
    logic [3:0] row_raw;
    logic [8:0] row_x20;

    assign x_oob   = px >= 10'(SCREEN_W);
    assign y_oob   = py >= 10'(SCREEN_H);
    assign oob     = x_oob | y_oob;

    // In-range coordinates keep col below 20 and row below 15, so the
    // truncated shifts lose nothing that matters.
    assign col_raw = 5'(px >> TILE_SHIFT);
    assign row_raw = 4'(py >> TILE_SHIFT);
    assign row     = y_oob ? 4'(MAP_ROWS) : row_raw;

    // row*20 without a multiplier: row*16 + row*4.
    assign row_x20   = ({5'd0, row_raw} << 4) + ({5'd0, row_raw} << 2);
    assign tile_addr = oob ? 9'd0 : row_x20 + {4'd0, col_raw};

endmodule

// File: rtl/kid_collision_scanner.sv
// kid_collision_scanner
//   Once per frame, probes the tile map around the Kid's current and
//   predicted box and reports landing / ceiling / ground / spike flags.
//   Clk, Reset_h          : system clock, synchronous active-high reset
//   frame_start           : one-cycle pulse starting a scan (ignored while busy)
//   PositionX/Y           : Kid top-left pixel position
//   MovementY             : vertical velocity, two's complement
//   tile_addr / tile_data : shared tile-map ROM port, 1-cycle read latency
//   busy, result_valid    : scan in progress / one-cycle result strobe
//   hit_y, Kid_position_Y         : feet landing flag and snap Y
//   hit_top, Kid_position_Y_top   : head ceiling flag and snap Y
//   Ground, collide               : standing on solid / touching a spike
//   Optional feature macro: KID_GOD_MODE_EN (no spike probes, collide held 0).
module kid_collision_scanner
    import kid_collision_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_h,
    input  logic       frame_start,
    input  logic [9:0] PositionX,
    input  logic [9:0] PositionY,
    input  logic [9:0] MovementY,
    output logic [8:0] tile_addr,
    input  logic [1:0] tile_data,
    output logic       busy,
    output logic       result_valid,
    output logic       hit_y,
    output logic [9:0] Kid_position_Y,
    output logic       hit_top,
    output logic [9:0] Kid_position_Y_top,
    output logic       Ground,
    output logic       collide
);

    scan_state_t state;
    scan_state_t state_nxt;
    probe_idx_t  idx;
    logic        start;

    logic [9:0]  x_l;
    logic [9:0]  y_l;
    logic [9:0]  ynext_l;
    logic        down_l;
    logic [3:0]  feet_row;
    logic [3:0]  head_row;

    logic [9:0]  probe_x_p0;
    logic [9:0]  probe_y_p0;
    logic        probe_used_p0;
    logic        oob_p0;
    logic [8:0]  addr_p0;
    logic [3:0]  row_p0;

    logic        vld_p1;
    logic        oob_p1;
    probe_idx_t  idx_p1;
    logic [1:0]  code_p1;

    logic        feet_acc, head_acc, gnd_acc, spike_acc;
    logic        feet_nxt, head_nxt, gnd_nxt, spike_nxt;

    assign start = (state == S_IDLE) && frame_start;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset_h) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (frame_start) state_nxt = S_PROBE;
            S_PROBE: if (idx == LAST_PROBE) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs; skipped and off-screen probes leave the ROM address at 0
    always_comb begin
        busy         = (state != S_IDLE);
        result_valid = (state == S_DONE);
        tile_addr    = (state == S_PROBE && probe_used_p0) ? addr_p0 : 9'd0;
    end

    // Scan parameters latched at start, probe slot counter
    always_ff @(posedge Clk) begin
        if (Reset_h)                idx <= '0;
        else if (start)             idx <= '0;
        else if (state == S_PROBE)  idx <= idx + 4'd1;
    end

    always_ff @(posedge Clk) begin
        if (start) begin
            x_l     <= PositionX;
            y_l     <= PositionY;
            ynext_l <= PositionY + MovementY;
            down_l  <= ~MovementY[9];
        end
        if (state == S_PROBE && idx == 4'd0) feet_row <= row_p0;
        if (state == S_PROBE && idx == 4'd2) head_row <= row_p0;
    end

    // Stage p0: probe point for the current slot
    always_comb begin
        probe_x_p0    = x_l + 10'd1;
        probe_y_p0    = ynext_l + 10'(KID_H - 1);
        probe_used_p0 = down_l;
        unique case (idx)
            4'd0: ;
            4'd1: probe_x_p0 = x_l + 10'(KID_W - 2);
            4'd2: begin
                probe_y_p0    = ynext_l;
                probe_used_p0 = ~down_l;
            end
            4'd3: begin
                probe_x_p0    = x_l + 10'(KID_W - 2);
                probe_y_p0    = ynext_l;
                probe_used_p0 = ~down_l;
            end
            4'd4: begin
                probe_y_p0    = y_l + 10'(KID_H);
                probe_used_p0 = 1'b1;
            end
            4'd5: begin
                probe_x_p0    = x_l + 10'(KID_W - 2);
                probe_y_p0    = y_l + 10'(KID_H);
                probe_used_p0 = 1'b1;
            end
            4'd6: begin
                probe_x_p0    = x_l + 10'd4;
                probe_y_p0    = y_l + 10'd4;
                probe_used_p0 = 1'b1;
            end
            4'd7: begin
                probe_x_p0    = x_l + 10'(KID_W - 5);
                probe_y_p0    = y_l + 10'd4;
                probe_used_p0 = 1'b1;
            end
            4'd8: begin
                probe_x_p0    = x_l + 10'd4;
                probe_y_p0    = y_l + 10'(KID_H - 5);
                probe_used_p0 = 1'b1;
            end
            4'd9: begin
                probe_x_p0    = x_l + 10'(KID_W - 5);
                probe_y_p0    = y_l + 10'(KID_H - 5);
                probe_used_p0 = 1'b1;
            end
            default: probe_used_p0 = 1'b0;
        endcase
    end

    kid_tile_addr u_tile_addr (
        .px        (probe_x_p0),
        .py        (probe_y_p0),
        .oob       (oob_p0),
        .tile_addr (addr_p0),
        .row       (row_p0)
    );

    // Stage p1: ROM data returns for the probe issued last cycle
    always_ff @(posedge Clk) begin
        if (Reset_h) vld_p1 <= 1'b0;
        else         vld_p1 <= (state == S_PROBE) && probe_used_p0;
        idx_p1 <= idx;
        oob_p1 <= oob_p0;
    end

    // Off-screen reads solid for the body probes, empty for spike probes.
    always_comb begin
        code_p1 = tile_data;
        if (oob_p1) code_p1 = (idx_p1 < P_SPIKE0) ? TILE_SOLID : TILE_EMPTY;
    end

    always_comb begin
        feet_nxt  = feet_acc  | (vld_p1 && idx_p1 <= 4'd1 && is_solid(code_p1));
        head_nxt  = head_acc  | (vld_p1 && (idx_p1 == 4'd2 || idx_p1 == 4'd3) && is_solid(code_p1));
        gnd_nxt   = gnd_acc   | (vld_p1 && (idx_p1 == 4'd4 || idx_p1 == 4'd5) && is_solid(code_p1));
        spike_nxt = spike_acc | (vld_p1 && idx_p1 >= P_SPIKE0 && is_spike(code_p1));
    end

    always_ff @(posedge Clk) begin
        if (Reset_h || start) begin
            feet_acc  <= 1'b0;
            head_acc  <= 1'b0;
            gnd_acc   <= 1'b0;
            spike_acc <= 1'b0;
        end else begin
            feet_acc  <= feet_nxt;
            head_acc  <= head_nxt;
            gnd_acc   <= gnd_nxt;
            spike_acc <= spike_nxt;
        end
    end

    // Stage p2: DRAIN folds in the last sample and publishes all results at once
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            hit_y              <= 1'b0;
            Kid_position_Y     <= '0;
            hit_top            <= 1'b0;
            Kid_position_Y_top <= '0;
            Ground             <= 1'b0;
            collide            <= 1'b0;
        end else if (state == S_DRAIN) begin
            hit_y              <= feet_nxt;
            Kid_position_Y     <= {1'b0, feet_row, 5'd0} - 10'(KID_H);
            hit_top            <= head_nxt;
            // Row 15 marks a head above the screen top (wrapped negative).
            Kid_position_Y_top <= (head_row == 4'(MAP_ROWS)) ? 10'd0
                                  : {({1'b0, head_row} + 5'd1), 5'd0};
            Ground             <= gnd_nxt;
`ifdef KID_GOD_MODE_EN
            collide            <= 1'b0;
`else
            collide            <= spike_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_kid_collision_scanner.sv
module tb_kid_collision_scanner;

    logic       Clk = 1'b0;
    logic       Reset_h = 1'b1;
    logic       frame_start = 1'b0;
    logic [9:0] PositionX = '0;
    logic [9:0] PositionY = '0;
    logic [9:0] MovementY = '0;
    logic [8:0] tile_addr;
    logic [1:0] tile_data = '0;
    logic       busy, result_valid, hit_y, hit_top, Ground, collide;
    logic [9:0] Kid_position_Y, Kid_position_Y_top;

`ifdef KID_GOD_MODE_EN
    localparam int EXP_LAT = 7;
    localparam bit GOD = 1'b1;
`else
    localparam int EXP_LAT = 11;
    localparam bit GOD = 1'b0;
`endif

    int n_pass = 0;
    int n_total = 0;

    logic [1:0] map [0:299];

    logic       e_hit_y, e_hit_top, e_ground, e_collide;
    logic [9:0] e_pos_y, e_pos_top;

    kid_collision_scanner dut (
        .Clk                (Clk),
        .Reset_h            (Reset_h),
        .frame_start        (frame_start),
        .PositionX          (PositionX),
        .PositionY          (PositionY),
        .MovementY          (MovementY),
        .tile_addr          (tile_addr),
        .tile_data          (tile_data),
        .busy               (busy),
        .result_valid       (result_valid),
        .hit_y              (hit_y),
        .Kid_position_Y     (Kid_position_Y),
        .hit_top            (hit_top),
        .Kid_position_Y_top (Kid_position_Y_top),
        .Ground             (Ground),
        .collide            (collide)
    );

    always #5 Clk = ~Clk;

    // Tile-map ROM model: one-cycle registered read.
    always @(posedge Clk) tile_data <= (tile_addr < 9'd300) ? map[tile_addr] : 2'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic clear_map();
        for (int i = 0; i < 300; i++) map[i] = 2'd0;
    endtask

    task automatic set_tile(input int col, input int row, input logic [1:0] code);
        map[row * 20 + col] = code;
    endtask

    // Reference model: tile seen at a pixel, from plain division.
    function automatic int tile_at(input int x, input int y, input bit spike_probe);
        if (x >= 640 || y >= 480) return spike_probe ? 0 : 1;
        return int'(map[(y / 32) * 20 + (x / 32)]);
    endfunction

    task automatic model(input int X, input int Y, input int M);
        int fy, hy, gy, frow, x1, x2, xa, xb, ya, yb;
        bit down;
        down = (M < 512);
        x1 = (X + 1) % 1024;
        x2 = (X + 30) % 1024;
        fy = (Y + M + 31) % 1024;
        hy = (Y + M) % 1024;
        gy = (Y + 32) % 1024;
        e_hit_y   = down && (tile_at(x1, fy, 0) == 1 || tile_at(x2, fy, 0) == 1);
        e_hit_top = !down && (tile_at(x1, hy, 0) == 1 || tile_at(x2, hy, 0) == 1);
        e_ground  = (tile_at(x1, gy, 0) == 1 || tile_at(x2, gy, 0) == 1);
        frow      = (fy >= 480) ? 15 : fy / 32;
        e_pos_y   = 10'((frow * 32 - 32 + 1024) % 1024);
        e_pos_top = (hy >= 480) ? 10'd0 : 10'((hy / 32 + 1) * 32);
        xa = (X + 4) % 1024;  xb = (X + 27) % 1024;
        ya = (Y + 4) % 1024;  yb = (Y + 27) % 1024;
        e_collide = !GOD && (tile_at(xa, ya, 1) == 2 || tile_at(xb, ya, 1) == 2 ||
                             tile_at(xa, yb, 1) == 2 || tile_at(xb, yb, 1) == 2);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".hit_y"},   32'(hit_y),              32'(e_hit_y));
        check({tag, ".pos_y"},   32'(Kid_position_Y),     32'(e_pos_y));
        check({tag, ".hit_top"}, 32'(hit_top),            32'(e_hit_top));
        check({tag, ".pos_top"}, 32'(Kid_position_Y_top), 32'(e_pos_top));
        check({tag, ".ground"},  32'(Ground),             32'(e_ground));
        check({tag, ".collide"}, 32'(collide),            32'(e_collide));
    endtask

    // Starts a scan (frame_start sampled at edge 0) and waits for result_valid.
    task automatic run_scan(input string tag, input int X, input int Y, input int M);
        int lat;
        model(X, Y, M);
        @(negedge Clk);
        PositionX = 10'(X); PositionY = 10'(Y); MovementY = 10'(M);
        frame_start = 1'b1;
        @(posedge Clk); #1;
        frame_start = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        lat = 0;
        do begin
            @(posedge Clk); #1;
            lat++;
        end while (!result_valid && lat < 40);
        check({tag, ".latency"}, 32'(lat), 32'(EXP_LAT));
        check_outputs(tag);
        repeat (3) @(posedge Clk);
        #1;
        check({tag, ".rv_low"}, 32'(result_valid), 32'd0);
        check({tag, ".hold_y"}, 32'(Kid_position_Y), 32'(e_pos_y));
        check({tag, ".hold_col"}, 32'(collide), 32'(e_collide));
    endtask

    initial begin
        int pulses, first;
        clear_map();

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        Reset_h = 1'b0;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.rv", 32'(result_valid), 32'd0);
        check("rst.addr", 32'(tile_addr), 32'd0);
        check("rst.hit_y", 32'(hit_y), 32'd0);
        check("rst.pos_y", 32'(Kid_position_Y), 32'd0);
        check("rst.collide", 32'(collide), 32'd0);

        // Open air
        run_scan("open", 100, 100, 4);
        check("open.hit_y_const", 32'(hit_y), 32'd0);

        // Landing on row 10
        for (int c = 0; c < 20; c++) set_tile(c, 10, 2'd1);
        run_scan("land", 100, 285, 6);
        check("land.snap", 32'(Kid_position_Y), 32'd288);

        // Ceiling at row 2
        clear_map();
        for (int c = 0; c < 20; c++) set_tile(c, 2, 2'd1);
        run_scan("ceil", 100, 100, 10'h3F0);
        check("ceil.snap", 32'(Kid_position_Y_top), 32'd96);

        // Spike at col 4 row 7
        clear_map();
        set_tile(4, 7, 2'd2);
        run_scan("spike", 120, 230, 0);
        check("spike.collide", 32'(collide), 32'(!GOD));

        // Screen floor
        clear_map();
        run_scan("floor", 200, 448, 2);
        check("floor.snap", 32'(Kid_position_Y), 32'd448);
        check("floor.ground", 32'(Ground), 32'd1);

        // Randomised scans
        for (int t = 0; t < 24; t++) begin
            int X, Y, M;
            clear_map();
            for (int i = 0; i < 300; i++)
                if ($urandom_range(0, 2) == 0) map[i] = 2'($urandom_range(0, 3));
            if (t % 2 == 0) begin
                X = $urandom_range(0, 1023);
                Y = $urandom_range(0, 1023);
                M = $urandom_range(0, 1023);
            end else begin
                X = $urandom_range(0, 608);
                Y = $urandom_range(0, 448);
                M = (1024 + $urandom_range(0, 40) - 20) % 1024;
            end
            run_scan($sformatf("rnd%0d", t), X, Y, M);
        end

        // frame_start while busy is ignored
        clear_map();
        set_tile(4, 7, 2'd2);
        model(120, 230, 0);
        @(negedge Clk);
        PositionX = 10'd120; PositionY = 10'd230; MovementY = 10'd0;
        frame_start = 1'b1;
        @(posedge Clk); #1;
        frame_start = 1'b0;
        pulses = 0; first = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k == 3) frame_start = 1'b1;
            @(posedge Clk); #1;
            if (k == 3) frame_start = 1'b0;
            if (result_valid) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        check("busy.pulses", 32'(pulses), 32'd1);
        check("busy.latency", 32'(first), 32'(EXP_LAT));
        check_outputs("busy");

        // Reset mid-scan
        clear_map();
        run_scan("prerst", 200, 448, 2);
        @(negedge Clk);
        frame_start = 1'b1;
        @(posedge Clk); #1;
        frame_start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        Reset_h = 1'b1;
        @(posedge Clk); #1;
        Reset_h = 1'b0;
        check("midrst.busy", 32'(busy), 32'd0);
        check("midrst.hit_y", 32'(hit_y), 32'd0);
        check("midrst.ground", 32'(Ground), 32'd0);
        check("midrst.pos_y", 32'(Kid_position_Y), 32'd0);
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge Clk); #1;
            if (result_valid) pulses++;
        end
        check("midrst.no_rv", 32'(pulses), 32'd0);

        // frame_start coincident with reset
        @(negedge Clk);
        Reset_h = 1'b1;
        frame_start = 1'b1;
        @(posedge Clk); #1;
        Reset_h = 1'b0;
        frame_start = 1'b0;
        check("coinc.busy", 32'(busy), 32'd0);
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge Clk); #1;
            if (result_valid || busy) pulses++;
        end
        check("coinc.idle", 32'(pulses), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
